// File: rtl/mat_pkg.sv
// -----------------------------------------------------------------------------
// mat_pkg
// Shared definitions for the packed-matrix bus used by mat_pack and the
// det/mul/sub/inverse datapaths. Element order is defined here once:
// element k of a packed matrix lives at [elem_lsb(k) +: DATA_WIDTH], row-major,
// element 0 (a) in the least significant bits.
// No ports (package).
// -----------------------------------------------------------------------------
package mat_pkg;

  localparam int unsigned DefDataWidth  = 8;
  localparam int unsigned DefMatrixSize = 4;  // 2x2
  localparam int unsigned DefCountWidth = $clog2(DefMatrixSize);

  // Bit offset of element k inside a packed matrix.
  function automatic int unsigned elem_lsb(input int unsigned k,
                                           input int unsigned dw = DefDataWidth);
    return k * dw;
  endfunction

endpackage

// File: rtl/mat_pack.sv
// -----------------------------------------------------------------------------
// mat_pack
// Element-serial to packed-matrix assembler. Accepts one element per
// in_valid/in_ready handshake, collects MATRIX_SIZE of them in a fill
// register and hands each complete matrix to an output register presented on
// out_valid/out_ready. Fill and output registers form a 2-deep pipeline so the
// next matrix can fill while the current one waits for the consumer.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_data    in   element value
//   in_valid   in   in_data valid
//   in_ready   out  element accepted this cycle (registered-derived)
//   in_last    in   final element of a matrix (checked only with frame check)
//   out_mat    out  packed matrix, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out  out_mat holds a complete matrix
//   out_ready  in   consumer takes out_mat this cycle
//   frame_err  out  one-cycle pulse: framing error, partial matrix dropped
//
// Build option: define MAT_PACK_FRAME_CHECK_EN to check in_last against the
// element count. Without it in_last is ignored and frame_err is tied low.
// -----------------------------------------------------------------------------
module mat_pack
  import mat_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned MATRIX_SIZE = DefMatrixSize
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] out_mat,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            frame_err
);

  localparam int unsigned CW = $clog2(MATRIX_SIZE);
  localparam int unsigned MW = DATA_WIDTH * MATRIX_SIZE;
  localparam logic [CW-1:0] LastIdx = CW'(MATRIX_SIZE - 1);

  // State
  logic [CW-1:0]         r_count;
  logic                  r_fill_full;
  logic [DATA_WIDTH-1:0] r_fill [MATRIX_SIZE];
  logic [MW-1:0]         r_out_mat;
  logic                  r_out_valid;
  logic                  r_frame_err;

  // Control
  logic          w_accept;
  logic          w_at_last;
  logic          w_err;
  logic          w_complete;
  logic          w_out_free;
  logic          w_xfer;
  logic [MW-1:0] w_fill_mat;

  assign in_ready  = ~r_fill_full;
  assign w_accept  = in_valid & ~r_fill_full;
  assign w_at_last = (r_count == LastIdx);

`ifdef MAT_PACK_FRAME_CHECK_EN
  // in_last must be high exactly on the element at count == MATRIX_SIZE-1.
  assign w_err = w_accept & (in_last != w_at_last);
`else
  logic w_unused_last;
  assign w_unused_last = in_last;
  assign w_err         = 1'b0;
`endif

  assign w_complete = w_accept & w_at_last & ~w_err;
  assign w_out_free = ~r_out_valid | out_ready;
  // A matrix moves to the output slot either from a full fill register or
  // straight from the element completing it this cycle.
  assign w_xfer     = (r_fill_full | w_complete) & w_out_free;

  // Fill contents as they will look after this cycle's element lands, so a
  // completing element can bypass into the output register on the same edge.
  always_comb begin
    w_fill_mat = '0;
    for (int unsigned k = 0; k < MATRIX_SIZE; k++) begin
      if (w_accept && (r_count == CW'(k))) begin
        w_fill_mat[elem_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = in_data;
      end else begin
        w_fill_mat[elem_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = r_fill[k];
      end
    end
  end

  // Fill storage needs no reset: its contents only matter once count and
  // fill_full say they are valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fill[r_count] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_accept) begin
      if (w_at_last || w_err) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_full <= 1'b0;
    end else if (w_xfer) begin
      r_fill_full <= 1'b0;
    end else if (w_complete) begin
      r_fill_full <= 1'b1;
    end
  end

  // Output slot: holds while stalled, reloads on transfer (even in the same
  // cycle as an output handshake), empties only on a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_mat   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_mat   <= w_fill_mat;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
    end
  end

  assign out_mat   = r_out_mat;
  assign out_valid = r_out_valid;

`ifdef MAT_PACK_FRAME_CHECK_EN
  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
  logic w_unused_ferr;
  assign w_unused_ferr = r_frame_err;
`endif

endmodule

// File: tb/tb_mat_pack.sv
// -----------------------------------------------------------------------------
// tb_mat_pack
// Directed testbench for mat_pack with a scoreboard of expected matrices.
// Honours MAT_PACK_FRAME_CHECK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mat_pack;
  import mat_pkg::*;

  localparam int unsigned DW = DefDataWidth;
  localparam int unsigned MS = DefMatrixSize;
  localparam int unsigned MW = DW * MS;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [MW-1:0] out_mat;
  logic          out_valid;
  logic          out_ready;
  logic          frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  logic [MW-1:0] sb[$];
  int            hs_cyc[$];

  // Bench-side model of the element being assembled.
  int            m_cnt = 0;
  logic [MW-1:0] m_mat = '0;

  mat_pack #(
    .DATA_WIDTH (DW),
    .MATRIX_SIZE(MS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .out_mat  (out_mat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on handshake plus hold-while-stalled check.
  logic          p_stall = 1'b0;
  logic [MW-1:0] p_mat   = '0;
  always @(negedge clk) begin
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_mat", {32'd0, out_mat}, {32'd0, p_mat});
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", {63'd0, (sb.size() != 0)}, 64'd1);
        if (sb.size() != 0) check("out_mat", {32'd0, out_mat}, {32'd0, sb.pop_front()});
        hs_cyc.push_back(cycle);
      end
      p_stall = out_valid && !out_ready;
      p_mat   = out_mat;
    end
  end

  // Apply one element; returns #1 after the edge that accepted it.
  task automatic send(input logic [DW-1:0] d, input logic l, input bit chk_rdy);
    logic rdy;
    bit   done;
    done     = 1'b0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      rdy = in_ready;
      if (chk_rdy && t == 0) check("in_ready_stream", {63'd0, rdy}, 64'd1);
      @(posedge clk);
      if (rdy) done = 1'b1;
    end
    #1;
    if (!done) begin
      check("send_timeout", 64'd0, 64'd1);
    end else begin
`ifdef MAT_PACK_FRAME_CHECK_EN
      if (l != (m_cnt == MS - 1)) begin
        m_cnt = 0;
        return;
      end
`endif
      m_mat[m_cnt*DW +: DW] = d;
      if (m_cnt == MS - 1) begin
        sb.push_back(m_mat);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && sb.size() != 0; t++) @(posedge clk);
    #1;
    check("drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_mat", {32'd0, out_mat}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single matrix, consumer always ready.
    send(8'd1, 1'b0, 1'b1);
    send(8'd2, 1'b0, 1'b1);
    send(8'd3, 1'b0, 1'b1);
    send(8'd4, 1'b1, 1'b1);
    check("t1_valid_after_last", {63'd0, out_valid}, 64'd1);
    check("t1_mat", {32'd0, out_mat}, {32'd0, 32'h04030201});
    idle_cycles(2);
    drain();

    // 2: three back-to-back matrices, handshakes spaced MS cycles apart.
    base = hs_cyc.size();
    for (int m = 0; m < 3; m++) begin
      for (int e = 0; e < 4; e++) send(DW'(16 * m + e + 5), (e == 3), 1'b1);
    end
    idle_cycles(3);
    drain();
    check("t2_hs_count", 64'(hs_cyc.size() - base), 64'd3);
    if (hs_cyc.size() >= base + 3) begin
      check("t2_gap0", 64'(hs_cyc[base+1] - hs_cyc[base]), 64'd4);
      check("t2_gap1", 64'(hs_cyc[base+2] - hs_cyc[base+1]), 64'd4);
    end

    // 3: back-pressure.
    out_ready = 1'b0;
    for (int e = 1; e <= 8; e++) send(DW'(e), ((e % 4) == 0), 1'b0);
    check("t3_in_ready_full", {63'd0, in_ready}, 64'd0);
    check("t3_held_mat", {32'd0, out_mat}, {32'd0, 32'h04030201});
    in_data  = 8'd9;
    in_last  = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t3_elem9_blocked", {63'd0, in_ready}, 64'd0);
    check("t3_still_held", {32'd0, out_mat}, {32'd0, 32'h04030201});
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t3_new_mat", {32'd0, out_mat}, {32'd0, 32'h08070605});
    check("t3_valid_kept", {63'd0, out_valid}, 64'd1);
    check("t3_in_ready_back", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // 4: reset mid-matrix discards the partial fill.
    send(8'd1, 1'b0, 1'b0);
    send(8'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    m_cnt    = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t4_rst_valid", {63'd0, out_valid}, 64'd0);
    send(8'd9, 1'b0, 1'b1);
    send(8'd8, 1'b0, 1'b1);
    send(8'd7, 1'b0, 1'b1);
    send(8'd6, 1'b1, 1'b1);
    check("t4_mat", {32'd0, out_mat}, {32'd0, 32'h06070809});
    idle_cycles(1);
    drain();

    // 5/6: in_last on the second element.
    send(8'd1, 1'b0, 1'b0);
    send(8'd2, 1'b1, 1'b0);
`ifdef MAT_PACK_FRAME_CHECK_EN
    check("t5_frame_err", {63'd0, frame_err}, 64'd1);
    check("t5_no_valid", {63'd0, out_valid}, 64'd0);
    idle_cycles(1);
    check("t5_err_pulse_end", {63'd0, frame_err}, 64'd0);
    send(8'd10, 1'b0, 1'b0);
    send(8'd11, 1'b0, 1'b0);
    send(8'd12, 1'b0, 1'b0);
    send(8'd13, 1'b1, 1'b0);
    check("t5_mat", {32'd0, out_mat}, {32'd0, 32'h0d0c0b0a});
`else
    check("t6_no_frame_err", {63'd0, frame_err}, 64'd0);
    idle_cycles(1);
    check("t6_no_frame_err2", {63'd0, frame_err}, 64'd0);
    send(8'd10, 1'b0, 1'b0);
    send(8'd11, 1'b0, 1'b0);
    check("t6_mat", {32'd0, out_mat}, {32'd0, 32'h0b0a0201});
    check("t6_valid", {63'd0, out_valid}, 64'd1);
    send(8'd12, 1'b0, 1'b0);
    send(8'd13, 1'b1, 1'b0);
`endif
    idle_cycles(2);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
